cdu_drive_scheduler: RTL
========================

// Module: cdu_drive_scheduler
// PURPOSE
//  Monitor-side scheduler that drives the five AGC CDU counters (X,Y,Z,T,S) toward
//  target angles set over the monitor register bus. On each 800 Hz tick, every enabled
//  channel whose position differs from its target raises one step request. A round-robin
//  arbiter serialises the requests onto a single counter-increment handshake (PCDU/MCDU).
// PARAMETERS
//  NUM_CH      5      number of CDU channels (sel 0..4 = X,Y,Z,T,S)
//  TIMEOUT     1023   cycles in REQ without ack before the step is abandoned
//  BASE_TGT    16'h00 register address of TARGET[0]; TARGET[n] = BASE_TGT+n
//  BASE_POS    16'h08 register address of POSITION[0]; POSITION[n] = BASE_POS+n
//  REG_CTRL    16'h10 enable mask register, bits [4:0]
//  REG_OVR     16'h11 overrun counter register (read-only; any write clears it)
//  REG_TMO     16'h12 timeout counter register (read-only; any write clears it)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  read_en     in   1   monitor register read strobe
//  write_en    in   1   monitor register write strobe
//  write_done  out  1   one-cycle write acknowledge
//  addr        in   16  register address
//  data_in     in   16  write data
//  data_out    out  16  read data; 0 when no read completed in the previous cycle
//  n800SET     in   1   800 Hz timing signal; rising edge = scheduling tick
//  cdu_req     out  1   step request to the AGC counter logic
//  cdu_sel     out  3   channel being stepped (valid while cdu_req)
//  cdu_dir     out  1   1 = plus (PCDU), 0 = minus (MCDU) (valid while cdu_req)
//  cdu_ack     in   1   counter logic has taken the step (single-cycle pulse)
// BEHAVIOUR
//  - One clock; rst_n is asynchronous and active-low. Reset clears all targets,
//    positions, ctrl, pending flags, counters and rr pointer (last=NUM_CH-1). It also
//    clears write_done, data_out, cdu_req, cdu_sel and cdu_dir. FSM enters IDLE.
//    A reset during REQ abandons the step immediately.
//  - Tick: n800SET is registered and the rising edge detected; tick is 1 cycle after the edge.
//  - Diff per channel: d = (target - position) mod 2^15. d==0: idle.
//    1..16383: plus. 16384..32767: minus (shortest path, ties go minus).
//  - On tick, for each channel with ctrl[n]=1 and d!=0: if pending[n] is already set,
//    OVR increments (saturates at 16'hFFFF); pending[n] is then set.
//    Clearing ctrl[n] also clears pending[n], unless n is the channel currently in REQ.
//  - FSM IDLE: if any pending, grant the first pending channel after `last` (round-robin).
//    cdu_sel is loaded and cdu_dir is taken from the current d. Go to REQ with cdu_req=1 next cycle.
//  - FSM REQ: cdu_req, cdu_sel and cdu_dir are held stable. On cdu_ack: position[sel] += 1
//    if dir else -= 1 (mod 2^15). pending[sel] is cleared, last<=sel, go to GAP.
//    If the wait counter reaches TIMEOUT first: TMO increments (saturating), pending[sel]
//    is cleared, position is unchanged, go to GAP.
//  - FSM GAP: cdu_req=0 for one cycle, then IDLE. Minimum 3 cycles between grants.
//  - cdu_ack outside REQ is ignored.
//  - Writes: write_done=1 the cycle after write_en, for any address.
//    TARGET/POSITION take data_in[14:0]. CTRL takes data_in[4:0].
//    Writes to unmapped addresses are acknowledged and otherwise ignored.
//  - Same-cycle POSITION write and ack on that channel: the write wins and the step is
//    dropped; pending is still cleared. A TARGET write never alters the in-flight cdu_dir.
//  - Reads: 1-cycle latency; data_out = read_data while read_done, else 0.
//    TARGET/POSITION read as {1'b0,value}. CTRL reads as {11'b0,mask}.
//    Unmapped addresses read 0.
// TESTING
//  1. Reset, POS0=0, TGT0=3, CTRL=1, ack 2 cycles after req -> 3 ticks give 3 plus steps
//     on sel=0; POS0 reads 3; no req on the 4th tick.
//  2. POS1=0, TGT1=15'h7FFE, CTRL=2 -> dir=0 (minus); after one ack POS1 reads 15'h7FFF
//     (wrap-around).
//  3. CTRL=5'h1F, all targets +1 from positions, ack immediate -> the one tick grants
//     sel 0,1,2,3,4 in order, each grant >=3 cycles apart.
//  4. TGT0 != POS0, CTRL=1, cdu_ack held 0 -> after TIMEOUT cycles req drops and TMO=1.
//     The next tick re-requests.
//  5. CTRL=1, never ack, TIMEOUT > 1 tick period -> the second tick while pending gives
//     OVR=1. A write to REG_OVR clears it to 0.
//  6. Assert rst_n low while cdu_req=1 -> cdu_req=0 asynchronously; all registers read 0
//     after release.

Source files
------------

// File: rtl/cdu_drive_scheduler.sv
// cdu_drive_scheduler
//   Drives the five CDU counters (X,Y,Z,T,S) toward target angles held in a small
//   monitor register file. Each 800 Hz tick marks every enabled, off-target channel
//   as pending; a round-robin arbiter then issues one step at a time on the
//   cdu_req/cdu_sel/cdu_dir handshake and waits for cdu_ack (or gives up on timeout).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   read_en, write_en     monitor register strobes (addr, data_in)
//   write_done            one-cycle write acknowledge
//   data_out              read data, one cycle after read_en, otherwise 0
//   n800SET               800 Hz timing input, rising edge = scheduling tick
//   cdu_req/sel/dir       step request, channel, direction (1 = PCDU, 0 = MCDU)
//   cdu_ack               single-cycle step acknowledge
//
// State | meaning
//   IDLE | waiting for a pending channel; grants one when found
//   REQ  | cdu_req high, waiting for cdu_ack or timeout
//   GAP  | one dead cycle so grants are at least 3 cycles apart
module cdu_drive_scheduler #(
    parameter int          NUM_CH   = 5,
    parameter int          TIMEOUT  = 1023,
    parameter logic [15:0] BASE_TGT = 16'h00,
    parameter logic [15:0] BASE_POS = 16'h08,
    parameter logic [15:0] REG_CTRL = 16'h10,
    parameter logic [15:0] REG_OVR  = 16'h11,
    parameter logic [15:0] REG_TMO  = 16'h12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_en,
    input  logic        write_en,
    output logic        write_done,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        n800SET,
    output logic        cdu_req,
    output logic [2:0]  cdu_sel,
    output logic        cdu_dir,
    input  logic        cdu_ack
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_GAP = 2'd2} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_set_d, r_set_d2, w_tick;
    logic [14:0]        r_tgt [NUM_CH];
    logic [14:0]        r_pos [NUM_CH];
    logic [14:0]        w_diff [NUM_CH];
    logic [NUM_CH-1:0]  r_ctrl, r_pending, w_pending_nxt;
    logic [2:0]         r_sel, r_last, w_grant_sel;
    logic               r_dir, w_grant_vld, w_grant_dir;
    logic [15:0]        r_wait, r_ovr, r_tmo, r_data_out, w_rd_data;
    logic               r_write_done;
    logic [15:0]        w_tgt_off, w_pos_off;
    logic               w_tgt_wr, w_pos_wr, w_ctrl_wr, w_ovr_wr, w_tmo_wr;
    logic               w_in_req, w_step, w_tmo_evt;
    logic [7:0]         w_ovr_inc;
    logic [16:0]        w_ovr_sum;

    assign w_tick     = r_set_d & ~r_set_d2;
    assign w_tgt_off  = addr - BASE_TGT;
    assign w_pos_off  = addr - BASE_POS;
    assign w_tgt_wr   = write_en && (w_tgt_off < 16'(NUM_CH));
    assign w_pos_wr   = write_en && (w_pos_off < 16'(NUM_CH));
    assign w_ctrl_wr  = write_en && (addr == REG_CTRL);
    assign w_ovr_wr   = write_en && (addr == REG_OVR);
    assign w_tmo_wr   = write_en && (addr == REG_TMO);

    assign write_done = r_write_done;
    assign data_out   = r_data_out;
    assign cdu_sel    = r_sel;
    assign cdu_dir    = r_dir;

    // Shortest-path distance; bit 14 set means the minus direction is shorter (or tied).
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_diff[n] = r_tgt[n] - r_pos[n];
        end
    end

    // Round-robin: first pending channel strictly after r_last.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_sel = '0;
        w_grant_dir = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(r_last) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!w_grant_vld && r_pending[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_sel = 3'(idx);
                w_grant_dir = ~w_diff[idx][14];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_nxt = S_REQ;
            S_REQ:   if (cdu_ack || r_wait == 16'd0) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_in_req  = (r_state == S_REQ);
        cdu_req   = w_in_req;
        w_step    = w_in_req && cdu_ack;
        w_tmo_evt = w_in_req && !cdu_ack && (r_wait == 16'd0);
    end

    // Pending flags and overrun count for this cycle.
    always_comb begin
        w_pending_nxt = r_pending;
        w_ovr_inc     = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if ((w_step || w_tmo_evt) && r_sel == 3'(n)) w_pending_nxt[n] = 1'b0;
            if (w_ctrl_wr && !data_in[n] && !(w_in_req && r_sel == 3'(n)))
                w_pending_nxt[n] = 1'b0;
            if (w_tick && r_ctrl[n] && w_diff[n] != 15'd0) begin
                if (r_pending[n]) w_ovr_inc = w_ovr_inc + 8'd1;
                w_pending_nxt[n] = 1'b1;
            end
        end
        w_ovr_sum = {1'b0, r_ovr} + 17'(w_ovr_inc);
    end

    always_comb begin
        w_rd_data = '0;
        if (w_tgt_off < 16'(NUM_CH))      w_rd_data = {1'b0, r_tgt[w_tgt_off[2:0]]};
        else if (w_pos_off < 16'(NUM_CH)) w_rd_data = {1'b0, r_pos[w_pos_off[2:0]]};
        else if (addr == REG_CTRL)        w_rd_data = 16'(r_ctrl);
        else if (addr == REG_OVR)         w_rd_data = r_ovr;
        else if (addr == REG_TMO)         w_rd_data = r_tmo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set_d      <= 1'b0;
            r_set_d2     <= 1'b0;
            r_ctrl       <= '0;
            r_pending    <= '0;
            r_sel        <= '0;
            r_last       <= 3'(NUM_CH - 1);
            r_dir        <= 1'b0;
            r_wait       <= '0;
            r_ovr        <= '0;
            r_tmo        <= '0;
            r_data_out   <= '0;
            r_write_done <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_tgt[n] <= '0;
                r_pos[n] <= '0;
            end
        end else begin
            r_set_d      <= n800SET;
            r_set_d2     <= r_set_d;
            r_write_done <= write_en;
            r_data_out   <= read_en ? w_rd_data : 16'd0;
            r_pending    <= w_pending_nxt;
            if (w_ctrl_wr) r_ctrl <= data_in[NUM_CH-1:0];

            if (r_state == S_IDLE && w_grant_vld) begin
                r_sel  <= w_grant_sel;
                r_dir  <= w_grant_dir;
                r_wait <= 16'(TIMEOUT - 1);
            end else if (w_in_req && r_wait != 16'd0) begin
                r_wait <= r_wait - 16'd1;
            end
            if (w_step) r_last <= r_sel;

            if (w_ovr_wr)           r_ovr <= '0;
            else if (w_ovr_sum[16]) r_ovr <= 16'hFFFF;
            else                    r_ovr <= w_ovr_sum[15:0];

            if (w_tmo_wr)                             r_tmo <= '0;
            else if (w_tmo_evt && r_tmo != 16'hFFFF) r_tmo <= r_tmo + 16'd1;

            // A same-cycle position write overrides the acknowledged step.
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_tgt_wr && w_tgt_off == 16'(n)) r_tgt[n] <= data_in[14:0];
                if (w_pos_wr && w_pos_off == 16'(n))
                    r_pos[n] <= data_in[14:0];
                else if (w_step && r_sel == 3'(n))
                    r_pos[n] <= r_dir ? r_pos[n] + 15'd1 : r_pos[n] - 15'd1;
            end
        end
    end

endmodule
